// File: rtl/stopwatch_pkg.sv
// Shared state encoding, field widths and default limits for the stopwatch
// time sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ADJUST = 2'd3
  } state_t;

  localparam int MIN_W       = 7;
  localparam int SEC_W       = 6;
  localparam int DEF_MAX_SEC = 59;
  localparam int DEF_MAX_MIN = 99;

endpackage

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) up-counter with synchronous clear; carry flags the
// increment that wraps MAX back to zero.
module wrap_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  assign carry = inc && (q == MAX_Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc)
      q <= carry ? '0 : q + WIDTH'(1);
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/clear/adjust FSM driving the minutes and
// seconds counters that feed the digit splitter.
//
// state     | meaning
// ST_IDLE   | time zero, stopped
// ST_RUN    | counting on tick_1hz
// ST_PAUSE  | time held, ticks ignored
// ST_ADJUST | tick_adj steps the field chosen by sel
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = DEF_MAX_MIN,
  parameter int MAX_SEC = DEF_MAX_SEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             tick_adj,
  input  logic             btn_pause,
  input  logic             btn_clear,
  input  logic             adj,
  input  logic             sel,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             running,
  output logic [1:0]       adj_field,
  output logic             overflow
);

  state_t state_q, state_d;
  logic   clr_time, run_tick, adj_sec_tick, adj_min_tick;
  logic   sec_inc, min_inc, sec_carry, min_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running   <= 1'b0;
      adj_field <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      running   <= (state_d == ST_RUN);
      adj_field <= (state_d == ST_ADJUST) ? (sel ? 2'b10 : 2'b01) : 2'b00;
      overflow  <= (state_q == ST_RUN) && min_carry;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_time     = 1'b0;
    run_tick     = 1'b0;
    adj_sec_tick = 1'b0;
    adj_min_tick = 1'b0;
    if (btn_clear) begin
      clr_time = 1'b1;
      state_d  = adj ? ST_ADJUST : ST_IDLE;
    end else if (adj) begin
      state_d = ST_ADJUST;
      if (state_q == ST_ADJUST) begin
        adj_sec_tick = tick_adj && !sel;
        adj_min_tick = tick_adj && sel;
      end
    end else begin
      case (state_q)
        ST_IDLE:   if (btn_pause) state_d = ST_RUN;
        ST_RUN: begin
          if (btn_pause) state_d = ST_PAUSE;
          else           run_tick = tick_1hz;
        end
        ST_PAUSE:  if (btn_pause) state_d = ST_RUN;
        ST_ADJUST: state_d = (minutes == '0 && seconds == '0) ? ST_IDLE : ST_PAUSE;
        default: begin
          state_d  = ST_IDLE;
          clr_time = 1'b1;
        end
      endcase
    end
  end

  // Seconds carry only reaches minutes in RUN; adjust steps fields independently.
  assign sec_inc = run_tick || adj_sec_tick;
  assign min_inc = run_tick ? sec_carry : adj_min_tick;

  wrap_counter #(.WIDTH(SEC_W), .MAX(MAX_SEC)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_time),
    .inc   (sec_inc),
    .q     (seconds),
    .carry (sec_carry)
  );

  wrap_counter #(.WIDTH(MIN_W), .MAX(MAX_MIN)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_time),
    .inc   (min_inc),
    .q     (minutes),
    .carry (min_carry)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl: run, overflow wrap,
// pause/tick collision, adjust stepping, clear priority and async reset.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, tick_adj, btn_pause, btn_clear, adj, sel;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running, overflow;
  logic [1:0] adj_field;

  int compared   = 0;
  int mismatched = 0;

  stopwatch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .tick_adj  (tick_adj),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .adj       (adj),
    .sel       (sel),
    .minutes   (minutes),
    .seconds   (seconds),
    .running   (running),
    .adj_field (adj_field),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int m, input int s);
    chk({tag, ".min"}, 32'(minutes), 32'(m));
    chk({tag, ".sec"}, 32'(seconds), 32'(s));
  endtask

  task automatic ticks(input int n);
    tick_1hz = 1'b1;
    repeat (n) step();
    tick_1hz = 1'b0;
  endtask

  task automatic adj_ticks(input int n);
    tick_adj = 1'b1;
    repeat (n) step();
    tick_adj = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
  endtask

  // Clear into ADJUST, step to mm:ss, release adj (-> PAUSE), then resume.
  task automatic preload_and_run(input int m, input int s);
    adj = 1'b1;
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    sel = 1'b1;
    adj_ticks(m);
    sel = 1'b0;
    adj_ticks(s);
    adj = 1'b0;
    step();
    press_pause();
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; tick_adj = 1'b0;
    btn_pause = 1'b0; btn_clear = 1'b0; adj = 1'b0; sel = 1'b0;

    // 1: reset state, then run 61 seconds
    step(); step();
    chk("rst.running", 32'(running), 32'd0);
    chk_time("rst", 0, 0);
    chk("rst.adj_field", 32'(adj_field), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();
    press_pause();
    chk("t1.running", 32'(running), 32'd1);
    ticks(61);
    chk_time("t1", 1, 1);
    chk("t1.running_after", 32'(running), 32'd1);

    // 2: preload 99:58, run through the overflow wrap
    adj = 1'b1;
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    sel = 1'b1;
    adj_ticks(99);
    sel = 1'b0;
    adj_ticks(58);
    chk_time("t2.preload", 99, 58);
    chk("t2.adj_field", 32'(adj_field), 32'd1);
    adj = 1'b0;
    step();
    chk("t2.pause_running", 32'(running), 32'd0);
    chk("t2.pause_adj_field", 32'(adj_field), 32'd0);
    press_pause();
    ticks(1);
    chk_time("t2.5959", 99, 59);
    chk("t2.ovf_before", 32'(overflow), 32'd0);
    ticks(1);
    chk_time("t2.wrap", 0, 0);
    chk("t2.ovf_pulse", 32'(overflow), 32'd1);
    chk("t2.running_wrap", 32'(running), 32'd1);
    step();
    chk("t2.ovf_clear", 32'(overflow), 32'd0);
    chk("t2.running_still", 32'(running), 32'd1);

    // 3: pause collides with tick at 00:10
    ticks(10);
    chk_time("t3.run", 0, 10);
    btn_pause = 1'b1; tick_1hz = 1'b1;
    step();
    btn_pause = 1'b0; tick_1hz = 1'b0;
    chk("t3.running", 32'(running), 32'd0);
    chk_time("t3.paused", 0, 10);
    ticks(5);
    chk_time("t3.held", 0, 10);

    // 4: adjust stepping, seconds wrap without carry
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    adj = 1'b1; sel = 1'b0;
    step();
    adj_ticks(61);
    chk_time("t4.sec", 0, 1);
    chk("t4.field_sec", 32'(adj_field), 32'd1);
    sel = 1'b1;
    adj_ticks(3);
    chk_time("t4.min", 3, 1);
    chk("t4.field_min", 32'(adj_field), 32'd2);
    chk("t4.running", 32'(running), 32'd0);
    adj = 1'b0;
    step();

    // 5: clear beats a simultaneous tick in RUN at 05:30
    preload_and_run(5, 30);
    chk_time("t5.run", 5, 30);
    chk("t5.running", 32'(running), 32'd1);
    btn_clear = 1'b1; tick_1hz = 1'b1;
    step();
    btn_clear = 1'b0; tick_1hz = 1'b0;
    chk_time("t5.clear", 0, 0);
    chk("t5.running_clear", 32'(running), 32'd0);
    ticks(2);
    chk_time("t5.idle_ticks", 0, 0);
    press_pause();
    chk("t5.resume", 32'(running), 32'd1);

    // 6: asynchronous reset mid-cycle at 12:34 in RUN
    preload_and_run(12, 34);
    chk_time("t6.run", 12, 34);
    chk("t6.running", 32'(running), 32'd1);
    tick_1hz = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_time("t6.async", 0, 0);
    chk("t6.async_running", 32'(running), 32'd0);
    step();
    #2 rst = 1'b0;
    step(); step(); step();
    tick_1hz = 1'b0;
    chk_time("t6.after", 0, 0);
    chk("t6.after_running", 32'(running), 32'd0);
    chk("t6.after_overflow", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencer for the stopwatch time registers that feed the digit splitter. It owns the minutes (0-99) and seconds (0-59) counters and advances them on a 1 Hz tick while running. It implements run, pause, clear and manual adjust from debounced button pulses, and drives the splitter inputs plus status flags for the display layer.

Parameters:
MAX_MIN, 99, highest minutes value before wrap; must be <= 127 to fit the 7-bit bus
MAX_SEC, 59, highest seconds value before carry into minutes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-cycle pulse at 1 Hz, clk-synchronous
tick_adj  in  1  one-cycle pulse at 2 Hz for adjust stepping, clk-synchronous
btn_pause  in  1  debounced one-cycle pulse; start/pause toggle
btn_clear  in  1  debounced one-cycle pulse; zero the time
adj  in  1  level; 1 = adjust mode
sel  in  1  level; adjust target, 0 = seconds, 1 = minutes
minutes  out  7  current minutes, 0..MAX_MIN
seconds  out  6  current seconds, 0..MAX_SEC
running  out  1  1 while state is RUN
adj_field  out  2  one-hot adjust target, bit1 = minutes, bit0 = seconds; 00 outside ADJUST
overflow  out  1  one-cycle pulse when MAX_MIN:MAX_SEC wraps to 00:00 in RUN

Behaviour:
- Clock and reset: one clock is used, clk. Reset rst is asynchronous and active-high. While rst is asserted, minutes=0, seconds=0, state=IDLE, running=0, adj_field=00, overflow=0.
- Registered outputs: every output is registered and reflects an input event on the clk edge after the event has been sampled (1-cycle latency).
- States: IDLE (zero, stopped), RUN, PAUSE, ADJUST.
- Per-cycle priority: btn_clear > adj > btn_pause > tick_1hz / tick_adj.
- btn_clear:
  - Sets minutes and seconds to 0 in any state.
  - Next state is ADJUST if adj=1, otherwise IDLE.
  - A tick or pause pulse in the same cycle is ignored.
- adj rising or held high: from any state, next state is ADJUST. btn_pause and tick_1hz are ignored while in ADJUST.
- ADJUST:
  - Each tick_adj increments the selected field by 1.
  - seconds wraps MAX_SEC->0 with no carry into minutes.
  - minutes wraps MAX_MIN->0.
  - adj_field follows sel combinationally-registered (1-cycle latency).
  - adj falling: next state is PAUSE, or IDLE if minutes=seconds=0.
- IDLE: btn_pause moves to RUN. tick_1hz is ignored.
- RUN:
  - On tick_1hz, seconds increments.
  - At seconds=MAX_SEC, seconds becomes 0 and minutes increments.
  - At MAX_MIN:MAX_SEC, both become 0, overflow pulses high for 1 cycle, and the state stays RUN.
  - btn_pause moves to PAUSE. A tick_1hz in the same cycle as btn_pause is discarded, so the time does not advance.
- PAUSE: btn_pause returns to RUN. Time is held and ticks are ignored.
- running is 1 exactly in RUN. overflow is 0 in all other cycles.
- Sub-second phase: none is kept. The first increment after resume occurs on the next tick_1hz.
- Reset mid-operation: asynchronous clear regardless of pending pulses. The first clk edge after rst deasserts samples inputs normally.
- Illegal state encodings recover to IDLE with the time cleared.
- No combinational path from inputs to outputs.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_ADJUST=2'd3
  - default MAX_SEC=59 and MAX_MIN=99
  - width constants MIN_W=7 and SEC_W=6
- Sub-module wrap_counter (params WIDTH, MAX):
  - inputs clk, rst, clr, inc
  - outputs q, carry; carry = inc and q==MAX
  - Instantiated twice, seconds and minutes.
- Minutes inc is driven in RUN by the seconds carry and in ADJUST by tick_adj&sel.
- The FSM lives in stopwatch_ctrl.

Test Plan:
1. Reset, btn_pause, then 61 tick_1hz -> running=1, minutes=1, seconds=1; running=0 during reset.
2. Preload 99:58 via adjust, release adj, btn_pause, 2 ticks -> 99:59 then 00:00 with overflow high exactly 1 cycle; running stays 1.
3. RUN at 00:10, btn_pause and tick_1hz in the same cycle -> state PAUSE, time 00:10. 5 more ticks -> still 00:10.
4. adj=1, sel=0, 61 tick_adj from 00:00 -> seconds=1, minutes=0, adj_field=01. sel=1, 3 tick_adj -> minutes=3, adj_field=10.
5. RUN at 05:30, btn_clear with a simultaneous tick_1hz -> 00:00, state IDLE, running=0. Next btn_pause -> RUN.
6. Assert rst asynchronously between clk edges while at 12:34 in RUN -> outputs zero before the next edge. Deassert -> IDLE, and ticks do not advance the time.
